// File: rtl/seq_tx_fmt_pkg.sv
// Shared definitions for the sequencer output formatter: FSM states and ASCII constants.
package seq_tx_fmt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DIGIT = 2'd1,
      ST_CR    = 2'd2,
      ST_LF    = 2'd3
   } fmt_state_e;

   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_DIGIT = 8'h30;
   localparam logic [7:0] ASCII_ALPHA = 8'h41;

endpackage

// File: rtl/seq_tx_fmt_fifo.sv
// Generic synchronous FIFO with async active-low reset; DEPTH must be a power of two.
module seq_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      push,
   input  logic [WIDTH-1:0]                          wdata,
   input  logic                                      pop,
   output logic [WIDTH-1:0]                          rdata,
   output logic                                      full,
   output logic                                      empty,
   output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1):0] count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign rdata   = mem[rptr];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Storage is left unreset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/seq_tx_fmt.sv
// Formats queued SEND values as uppercase hex digits plus CR LF, one byte per handshake.
module seq_tx_fmt
   import seq_tx_fmt_pkg::*;
#(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              send_vld,
   input  logic [DATA_W-1:0] send_data,
   output logic              send_rdy,
   output logic              send_ovf,
   output logic [7:0]        tx_data,
   output logic              tx_vld,
   input  logic              tx_rdy,
   output logic              busy
);

   localparam int unsigned DIGITS = DATA_W / 4;
   localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned FAW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   fmt_state_e        state, state_nxt;
   logic [DATA_W-1:0] val, val_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_rdata;
   logic [FAW:0]      fifo_count;

   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      if (nib < 4'd10) return ASCII_DIGIT + {4'h0, nib};
      else             return ASCII_ALPHA + {4'h0, nib} - 8'd10;
   endfunction

   seq_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (send_vld),
      .wdata (send_data),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign send_rdy = ~fifo_full;
   assign busy     = (state != ST_IDLE) || (fifo_count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         val      <= '0;
         cnt      <= '0;
         send_ovf <= 1'b0;
      end else begin
         state    <= state_nxt;
         val      <= val_nxt;
         cnt      <= cnt_nxt;
         send_ovf <= send_vld & ~send_rdy;
      end
   end

   always_comb begin
      state_nxt = state;
      val_nxt   = val;
      cnt_nxt   = cnt;
      pop       = 1'b0;
      tx_vld    = 1'b0;
      tx_data   = '0;
      unique case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               val_nxt   = fifo_rdata;
               cnt_nxt   = '0;
               state_nxt = ST_DIGIT;
            end
         end
         ST_DIGIT: begin
            tx_vld  = 1'b1;
            tx_data = hex_char(val[DATA_W-1 -: 4]);
            if (tx_rdy) begin
               val_nxt = val << 4;
               cnt_nxt = cnt + 1'b1;
               if (cnt == CNT_W'(DIGITS - 1)) state_nxt = ST_CR;
            end
         end
         ST_CR: begin
            tx_vld  = 1'b1;
            tx_data = ASCII_CR;
            if (tx_rdy) state_nxt = ST_LF;
         end
         ST_LF: begin
            tx_vld  = 1'b1;
            tx_data = ASCII_LF;
            if (tx_rdy) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_seq_tx_fmt.sv
// Directed bench for seq_tx_fmt: frame-level byte model plus literal per-cycle expectations.
module tb_seq_tx_fmt;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        send_vld = 1'b0;
   logic [15:0] send_data = '0;
   logic        send_rdy;
   logic        send_ovf;
   logic [7:0]  tx_data;
   logic        tx_vld;
   logic        tx_rdy = 1'b0;
   logic        busy;

   int total = 0;
   int bad = 0;

   logic [7:0] exp_q[$];
   string      lut = "0123456789ABCDEF";

   seq_tx_fmt #(
      .DATA_W     (16),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .send_vld  (send_vld),
      .send_data (send_data),
      .send_rdy  (send_rdy),
      .send_ovf  (send_ovf),
      .tx_data   (tx_data),
      .tx_vld    (tx_vld),
      .tx_rdy    (tx_rdy),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected byte stream of one frame: four hex characters MSB first, then CR LF.
   task automatic model_frame(input logic [15:0] v);
      for (int d = 0; d < 4; d++) begin
         logic [3:0] nib;
         nib = v[15 - 4*d -: 4];
         exp_q.push_back(lut.getc(int'(nib)));
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   // Every cycle: order of transferred bytes and hold-until-transfer behaviour.
   logic       pv = 1'b0;
   logic [7:0] pd = '0;
   logic       pt = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         pv = 1'b0;
         pt = 1'b0;
      end else begin
         if (pv && !pt) begin
            chk("hold_vld", tx_vld, 1);
            chk("hold_data", tx_data, pd);
         end
         if (tx_vld && tx_rdy) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_byte: got %0h want none at %0t", tx_data, $time);
            end else begin
               chk("stream", tx_data, exp_q.pop_front());
            end
         end
         pv = tx_vld;
         pd = tx_data;
         pt = tx_vld && tx_rdy;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [7:0] f2 [6];
      logic [7:0] f3 [18];
      logic [7:0] f4 [5];
      int k;
      f2 = '{8'h30, 8'h30, 8'h34, 8'h30, 8'h0D, 8'h0A};
      f3 = '{8'h30, 8'h30, 8'h30, 8'h33, 8'h0D, 8'h0A,
             8'h30, 8'h30, 8'h43, 8'h30, 8'h0D, 8'h0A,
             8'h30, 8'h31, 8'h30, 8'h30, 8'h0D, 8'h0A};
      f4 = '{8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};

      // Reset state and quiet idle
      repeat (3) @(negedge clk);
      chk("rst_tx_vld", tx_vld, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_send_rdy", send_rdy, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", send_ovf, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tx_rdy = 1'b1;
      n = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx_vld) n++;
      end
      chk("quiet_after_reset", n, 0);

      // Single frame 0x0040 with exact latency
      @(posedge clk); #1;
      send_vld = 1'b1;
      send_data = 16'h0040;
      model_frame(16'h0040);
      @(posedge clk); #1;
      send_vld = 1'b0;
      @(negedge clk);
      chk("f1_first_cycle_vld", tx_vld, 0);
      chk("f1_first_cycle_busy", busy, 1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("f1_vld", tx_vld, 1);
         chk("f1_data", tx_data, f2[i]);
      end
      @(negedge clk);
      chk("f1_end_vld", tx_vld, 0);
      chk("f1_end_busy", busy, 0);

      // Three back-to-back sends, one bubble between frames
      model_frame(16'h0003);
      model_frame(16'h00C0);
      model_frame(16'h0100);
      k = 0;
      for (int j = 0; j <= 22; j++) begin
         logic expv;
         @(posedge clk); #1;
         send_vld = (j < 3);
         send_data = (j == 0) ? 16'h0003 : (j == 1) ? 16'h00C0 : 16'h0100;
         @(negedge clk);
         expv = (j >= 2) && (((j - 1) % 7) != 0);
         chk("b2b_vld", tx_vld, expv);
         if (expv) begin
            chk("b2b_data", tx_data, f3[k]);
            k++;
         end
      end
      send_vld = 1'b0;
      chk("b2b_busy_end", busy, 0);

      // Back-pressure while second digit of 0xBEEF is presented
      @(posedge clk); #1;
      send_vld = 1'b1;
      send_data = 16'hBEEF;
      model_frame(16'hBEEF);
      @(posedge clk); #1;
      send_vld = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("bp_first", tx_data, 8'h42);
      @(posedge clk); #1;
      tx_rdy = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("bp_hold_vld", tx_vld, 1);
         chk("bp_hold_data", tx_data, 8'h45);
         @(posedge clk); #1;
      end
      tx_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_vld", tx_vld, 1);
         chk("bp_data", tx_data, f4[i]);
      end
      @(negedge clk);
      chk("bp_end_vld", tx_vld, 0);

      // Overflow: five accepted while stalled, sixth dropped
      @(posedge clk); #1;
      tx_rdy = 1'b0;
      for (int v = 1; v <= 6; v++) begin
         @(posedge clk); #1;
         send_vld = 1'b1;
         send_data = 16'(v);
         if (v <= 5) model_frame(16'(v));
         @(negedge clk);
         chk("ovf_send_rdy", send_rdy, (v <= 5));
         chk("ovf_no_early_pulse", send_ovf, 0);
      end
      @(posedge clk); #1;
      send_vld = 1'b0;
      @(negedge clk);
      chk("ovf_pulse", send_ovf, 1);
      chk("ovf_still_full", send_rdy, 0);
      @(negedge clk);
      chk("ovf_pulse_end", send_ovf, 0);
      @(posedge clk); #1;
      tx_rdy = 1'b1;
      n = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx_vld && tx_rdy) n++;
      end
      chk("ovf_byte_count", n, 30);
      chk("ovf_drained", exp_q.size(), 0);
      chk("ovf_busy_end", busy, 0);

      // Reset mid-frame with two requests queued
      @(posedge clk); #1;
      tx_rdy = 1'b0;
      send_vld = 1'b1;
      send_data = 16'h1234;
      model_frame(16'h1234);
      @(posedge clk); #1;
      send_data = 16'h5678;
      @(posedge clk); #1;
      send_data = 16'h9ABC;
      @(posedge clk); #1;
      send_vld = 1'b0;
      tx_rdy = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      tx_rdy = 1'b0;
      @(negedge clk);
      chk("mid_vld", tx_vld, 1);
      chk("mid_digit3", tx_data, 8'h33);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_vld", tx_vld, 0);
      chk("mid_rst_data", tx_data, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_send_rdy", send_rdy, 1);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tx_rdy = 1'b1;
      n = 0;
      repeat (50) begin
         @(negedge clk);
         if (tx_vld) n++;
      end
      chk("mid_rst_quiet", n, 0);
      chk("mid_rst_busy_after", busy, 0);

      chk("final_queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_tx_fmt.md
# seq_tx_fmt

Output formatter for the calculator sequencer: takes register values produced by SEND instructions and emits each as four uppercase ASCII hex digits, MSB first, followed by CR LF. Output goes one byte at a time over a valid/ready handshake to the UART transmitter. It sits directly downstream of the sequencer's SEND path and upstream of the UART TX. A small request FIFO absorbs back-to-back SENDs while the UART is busy.

## Interface
- `DATA_W`, 16: width of a sent value; must be a multiple of 4; digits per frame = DATA_W/4.
- `FIFO_DEPTH`, 4: pending-request FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `send_vld`  in  1  sequencer presents a value to send.
- `send_data`  in  DATA_W  value to format.
- `send_rdy`  out  1  FIFO not full; request accepted at an edge where `send_vld & send_rdy`.
- `send_ovf`  out  1  one-cycle pulse when `send_vld` is high while `send_rdy` is low; the request is dropped.
- `tx_data`  out  8  ASCII byte to UART.
- `tx_vld`  out  1  `tx_data` is valid.
- `tx_rdy`  in  1  UART accepts; a byte transfers at an edge where `tx_vld & tx_rdy`.
- `busy`  out  1  FSM not in IDLE, or FIFO non-empty.

## Operation
- FIFO: accepts `send_data` on `send_vld & send_rdy` and pops on FSM load. Push and pop may occur in the same cycle, leaving the count unchanged. `send_rdy = (count != FIFO_DEPTH)`.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into shift register `val`, clear digit counter, go to DIGIT.
  - DIGIT: `tx_vld=1`, `tx_data=hex(val[DATA_W-1 -: 4])`. On transfer, shift `val` left by 4 and increment the counter. After the last digit, go to CR.
  - CR: `tx_vld=1`, `tx_data=8'h0D`. On transfer, go to LF.
  - LF: `tx_vld=1`, `tx_data=8'h0A`. On transfer, go to IDLE.
- Hex mapping: 0–9 → 8'h30–8'h39; A–F → 8'h41–8'h46. Uppercase only.
- Leading zeros are always emitted; every frame is exactly DATA_W/4+2 bytes.
- Handshake: once `tx_vld` is high, `tx_vld` and `tx_data` stay stable until transfer. `tx_vld` never drops without a transfer, except on reset.
- `tx_rdy` is ignored while `tx_vld` is low.
- Requests are transmitted in acceptance order. No frame is interleaved or truncated.
- Reset values: `tx_vld=0`, `tx_data=8'h00`, `send_rdy=1`, `send_ovf=0`, `busy=0`, FIFO empty, FSM IDLE.

## Timing
- Accept at edge N (FIFO was empty, FSM IDLE) → pop at edge N+1 → `tx_vld` high with first digit in cycle N+1 (after edge N+1).
- With `tx_rdy` held high, a frame occupies 6 consecutive cycles for DATA_W=16.
- After the LF transfer there is one IDLE bubble cycle, then the next frame starts if the FIFO is non-empty.
- Capacity while output is stalled = FIFO_DEPTH + 1: one value is held in `val` and FIFO_DEPTH values wait in the FIFO.
- `send_ovf` is registered: it asserts the cycle after the dropped request's edge and lasts one cycle per dropped cycle.
- Asserting `rst_n` low mid-frame clears everything immediately (asynchronously): `tx_vld` falls without a transfer, and the partial frame and queued requests are discarded. After release, nothing is emitted until a new send is accepted.
- `rst_n` release is synchronised by the top level; the block assumes deassertion is clean with respect to `clk`.

## Structure
- `seq_definitions.v` gains:
  - the FSM state encodings (IDLE, DIGIT, CR, LF; 2-bit);
  - ASCII constants: CR 8'h0D, LF 8'h0A, digit base 8'h30, alpha base 8'h41.
- One sub-module, `seq_fifo`:
  - parameterised width/depth, synchronous push/pop, full/empty/count, async active-low reset;
  - reusable for a future RX command queue.
- The hex-digit mapping is a local function in `seq_tx_fmt`.

## Test plan
- Reset: hold `rst_n` low → `tx_vld=0`, `send_rdy=1`, `busy=0`, `send_ovf=0`. Release with no sends → no transfers for 100 cycles.
- Send 16'h0040 with `tx_rdy=1` → bytes 30 30 34 30 0D 0A on six consecutive cycles, `tx_vld` first high two edges after accept, `busy` falls after LF.
- Sends 16'h0003, 16'h00C0, 16'h0100 back-to-back, `tx_rdy=1`:
  - expected streams: 30 30 30 33 0D 0A / 30 30 43 30 0D 0A / 30 31 30 30 0D 0A;
  - uppercase 'C' (43), in order, one bubble cycle between frames.
- Back-pressure: 16'hBEEF, drop `tx_rdy` for 10 cycles while the second digit (45) is presented → `tx_data` holds 45 and `tx_vld` holds 1. Frame completes as 42 45 45 46 0D 0A.
- Overflow: `tx_rdy=0`, six sends on consecutive cycles (values 1–6):
  - first five accepted; `send_rdy` low on the sixth; one `send_ovf` pulse;
  - after `tx_rdy=1`, frames for values 1–5 only.
- Reset mid-frame: pull `rst_n` low while digit 3 is pending with `tx_rdy=0` and two requests queued → `tx_vld` falls immediately, FIFO is empty, and no bytes follow after release.
